// File: rtl/ser_pkg.sv
// Shared definitions for the serializer transmit scheduler: FSM state
// encoding, serializer byte width and the default divider width.
package ser_pkg;

   localparam int SER_BYTE_W    = 8;
   localparam int SER_DIV_W_DEF = 32;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_LOAD       = 3'd1,
      ST_WAIT_START = 3'd2,
      ST_WAIT_DONE  = 3'd3,
      ST_ACK        = 3'd4
   } ser_state_t;

endpackage

// File: rtl/ser_tx_scheduler_rr_pick.sv
// rr_pick: combinational round-robin selector. Among the set request bits,
// returns the one closest after 'last' (wrapping modulo NUM_REQ).
module rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 3
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last,
   output logic [IDX_W-1:0]   index,
   output logic               valid
);

   int dist_s;
   int best_s;

   // Pick the requester with the smallest circular distance past 'last'.
   always_comb begin
      index  = '0;
      valid  = 1'b0;
      best_s = NUM_REQ;
      dist_s = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         dist_s = (i + 2 * NUM_REQ - int'(last) - 1) % NUM_REQ;
         if (req[i] && (dist_s < best_s)) begin
            best_s = dist_s;
            index  = IDX_W'(i);
            valid  = 1'b1;
         end else begin
            best_s = best_s;
         end
      end
   end

endmodule

// File: rtl/ser_tx_scheduler.sv
// ser_tx_scheduler: shares one byte serializer between NUM_REQ requesters
// with round-robin arbitration. Latches the winner's byte and divider,
// strobes the serializer, follows its empty flag through one transfer and
// acks the winner. Optional watchdog: define SER_TX_TIMEOUT_EN.
module ser_tx_scheduler
   import ser_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int DIV_W       = SER_DIV_W_DEF,
   parameter int TIMEOUT_CYC = 65535
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ*SER_BYTE_W-1:0] req_data,
   input  logic [NUM_REQ*DIV_W-1:0]   req_div,
   output logic [NUM_REQ-1:0]         ack,
   output logic [2:0]                 grant_id,
   output logic                       busy,
   output logic                       err,
   output logic [SER_BYTE_W-1:0]      ser_par_data,
   output logic [DIV_W-1:0]           ser_divider,
   output logic                       ser_store,
   input  logic                       ser_empty
);

   localparam int IDX_W = 3;
   localparam logic [NUM_REQ-1:0] ACK_LSB = {{(NUM_REQ-1){1'b0}}, 1'b1};

   ser_state_t              state_r;
   logic [IDX_W-1:0]        last_r;
   logic [IDX_W-1:0]        grant_id_r;
   logic                    busy_r;
   logic [NUM_REQ-1:0]      ack_r;
   logic                    ser_store_r;
   logic [SER_BYTE_W-1:0]   data_r;
   logic [DIV_W-1:0]        div_r;

   logic [IDX_W-1:0]        pick_idx_s;
   logic                    pick_valid_s;
   logic [SER_BYTE_W-1:0]   sel_data_s;
   logic [DIV_W-1:0]        sel_div_s;
   logic                    wd_hit_s;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_pick (
      .req   (req),
      .last  (last_r),
      .index (pick_idx_s),
      .valid (pick_valid_s)
   );

   // Route the selected requester's byte and divider slices.
   always_comb begin
      sel_data_s = '0;
      sel_div_s  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick_idx_s == IDX_W'(i)) begin
            sel_data_s = req_data[i*SER_BYTE_W +: SER_BYTE_W];
            sel_div_s  = req_div[i*DIV_W +: DIV_W];
         end else begin
            sel_data_s = sel_data_s;
         end
      end
   end

`ifdef SER_TX_TIMEOUT_EN
   localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYC - 1);

   logic [15:0] wd_r;
   logic        err_r;
   logic        stall_s;

   // A WAIT state that is not about to make progress this cycle.
   always_comb begin
      case (state_r)
         ST_WAIT_START: stall_s = ser_empty;
         ST_WAIT_DONE:  stall_s = ~ser_empty;
         default:       stall_s = 1'b0;
      endcase
   end

   assign wd_hit_s = stall_s && (wd_r == WD_LAST);

   // Watchdog: cleared on entry to each WAIT state, counts cycles spent there.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wd_r <= 16'd0;
      end else if ((state_r == ST_LOAD) ||
                   ((state_r == ST_WAIT_START) && !ser_empty)) begin
         wd_r <= 16'd0;
      end else if ((state_r == ST_WAIT_START) || (state_r == ST_WAIT_DONE)) begin
         wd_r <= wd_r + 16'd1;
      end else begin
         wd_r <= 16'd0;
      end
   end

   // One-cycle abort pulse when the watchdog expires.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         err_r <= 1'b0;
      end else begin
         err_r <= wd_hit_s;
      end
   end

   assign err = err_r;
`else
   assign wd_hit_s = 1'b0;
   // No watchdog in this build; TIMEOUT_CYC is inert and err stays low.
   assign err = (TIMEOUT_CYC < 0) ? 1'b1 : 1'b0;
`endif

   // Transfer FSM with registered serializer controls, ack and status.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r     <= ST_IDLE;
         last_r      <= IDX_W'(NUM_REQ - 1);
         grant_id_r  <= 3'd0;
         busy_r      <= 1'b0;
         ack_r       <= '0;
         ser_store_r <= 1'b0;
         data_r      <= '0;
         div_r       <= '0;
      end else begin
         ack_r       <= '0;
         ser_store_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (pick_valid_s) begin
                  grant_id_r  <= pick_idx_s;
                  last_r      <= pick_idx_s;
                  data_r      <= sel_data_s;
                  div_r       <= sel_div_s;
                  ser_store_r <= 1'b1;
                  busy_r      <= 1'b1;
                  state_r     <= ST_LOAD;
               end else begin
                  busy_r      <= 1'b0;
               end
            end
            ST_LOAD: begin
               state_r <= ST_WAIT_START;
            end
            // Serializer's empty flag may still read high right after the store.
            ST_WAIT_START: begin
               if (!ser_empty) begin
                  state_r <= ST_WAIT_DONE;
               end else if (wd_hit_s) begin
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
               end else begin
                  state_r <= ST_WAIT_START;
               end
            end
            ST_WAIT_DONE: begin
               if (ser_empty) begin
                  state_r <= ST_ACK;
                  ack_r   <= ACK_LSB << grant_id_r;
               end else if (wd_hit_s) begin
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
               end else begin
                  state_r <= ST_WAIT_DONE;
               end
            end
            ST_ACK: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
            end
            default: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign ack          = ack_r;
   assign grant_id     = grant_id_r;
   assign busy         = busy_r;
   assign ser_par_data = data_r;
   assign ser_divider  = div_r;
   assign ser_store    = ser_store_r;

endmodule

// File: tb/tb_ser_tx_scheduler.sv
// Testbench for ser_tx_scheduler: directed scenarios plus randomized
// transfers, checked against a transaction-level round-robin model.
module tb_ser_tx_scheduler;

   localparam int N  = 4;
   localparam int DW = 32;

   logic            clock = 1'b0;
   logic            reset;
   logic [N-1:0]    req;
   logic [N*8-1:0]  req_data;
   logic [N*DW-1:0] req_div;
   logic [N-1:0]    ack;
   logic [2:0]      grant_id;
   logic            busy;
   logic            err;
   logic [7:0]      ser_par_data;
   logic [DW-1:0]   ser_divider;
   logic            ser_store;
   logic            ser_empty;

   int err_cnt = 0;
   int chk_cnt = 0;
   int model_last;
   logic [7:0]    data_q [N];
   logic [DW-1:0] div_q  [N];

   ser_tx_scheduler #(
      .NUM_REQ     (N),
      .DIV_W       (DW),
      .TIMEOUT_CYC (20)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .req          (req),
      .req_data     (req_data),
      .req_div      (req_div),
      .ack          (ack),
      .grant_id     (grant_id),
      .busy         (busy),
      .err          (err),
      .ser_par_data (ser_par_data),
      .ser_divider  (ser_divider),
      .ser_store    (ser_store),
      .ser_empty    (ser_empty)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Round-robin rule: first active requester after the last winner, circularly.
   function automatic int rr_model(input logic [N-1:0] m, input int last);
      for (int k = 1; k <= N; k++) begin
         if (m[(last + k) % N]) return (last + k) % N;
      end
      return -1;
   endfunction

   task automatic drive_req(input logic [N-1:0] mask);
      req = mask;
      for (int i = 0; i < N; i++) begin
         req_data[i*8 +: 8]   = data_q[i];
         req_div[i*DW +: DW]  = div_q[i];
      end
   endtask

   // One full transfer. from_ack: the DUT is currently in its ACK cycle.
   task automatic do_xfer(input logic [N-1:0] mask, input int lag, input int len,
                          input bit drop, input bit from_ack);
      int w;
      logic [N-1:0] exp_ack;
      w = rr_model(mask, model_last);
      drive_req(mask);
      if (from_ack) begin
         tick();
         check("idle_busy", busy, 0);
         check("idle_store", ser_store, 0);
         check("idle_ack", ack, 0);
      end
      tick();
      check("store", ser_store, 1);
      check("data", ser_par_data, data_q[w]);
      check("div", ser_divider, div_q[w]);
      check("grant_id", grant_id, w);
      check("busy", busy, 1);
      model_last = w;
      tick();
      check("store_once", ser_store, 0);
      for (int i = 0; i < lag; i++) begin
         tick();
         check("early_ack", ack, 0);
      end
      ser_empty = 1'b0;
      for (int i = 0; i < len; i++) begin
         tick();
         check("run_ack", ack, 0);
         if (drop && i == 0) req[w] = 1'b0;
      end
      ser_empty = 1'b1;
      tick();
      exp_ack = 4'b0001 << w;
      check("ack", ack, exp_ack);
      check("ack_busy", busy, 1);
      check("err", err, 0);
      data_q[w] = 8'($urandom);
      div_q[w]  = $urandom;
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin
         data_q[i] = 8'($urandom);
         div_q[i]  = $urandom;
      end
      reset = 1'b1;
      ser_empty = 1'b1;
      drive_req(4'b0000);
      #1;
      check("rst_ack", ack, 0);
      check("rst_gid", grant_id, 0);
      check("rst_busy", busy, 0);
      check("rst_err", err, 0);
      check("rst_data", ser_par_data, 0);
      check("rst_div", ser_divider, 0);
      check("rst_store", ser_store, 0);
      tick();
      tick();
      reset = 1'b0;
      model_last = N - 1;
      tick();
      check("idle_busy0", busy, 0);

      // Single request from requester 1.
      data_q[1] = 8'hA5;
      div_q[1]  = 32'd10;
      do_xfer(4'b0010, 0, 8, 1'b0, 1'b0);

      // All four requesting: rotation.
      for (int t = 0; t < 5; t++) do_xfer(4'b1111, 0, 2, 1'b0, 1'b1);

      // Request 2 dropped during WAIT_DONE; next grant skips it.
      model_last = model_last;
      do_xfer(4'b0100, 0, 3, 1'b1, 1'b1);
      do_xfer(4'b1011, 0, 2, 1'b0, 1'b1);

      // Slow empty response.
      do_xfer(4'b1000, 3, 4, 1'b0, 1'b1);

      // Randomized transfers.
      for (int t = 0; t < 40; t++) begin
         do_xfer(4'($urandom_range(1, 15)), $urandom_range(0, 3),
                 $urandom_range(1, 8), ($urandom_range(0, 3) == 0), 1'b1);
      end

      // Hold check after the transfer, then reset in WAIT_DONE.
      tick();
      check("hold_busy", busy, 0);
      drive_req(4'b0110);
      tick();
      check("pre_rst_store", ser_store, 1);
      tick();
      ser_empty = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      #1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_ack", ack, 0);
      check("mid_rst_store", ser_store, 0);
      ser_empty = 1'b1;
      tick();
      reset = 1'b0;
      model_last = N - 1;
      do_xfer(4'b1111, 1, 3, 1'b0, 1'b0);

`ifdef SER_TX_TIMEOUT_EN
      begin
         int w;
         bit seen;
         tick();
         drive_req(4'b1111);
         w = rr_model(4'b1111, model_last);
         tick();
         check("wd_store", ser_store, 1);
         check("wd_gid", grant_id, w);
         model_last = w;
         seen = 1'b0;
         for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            check("wd_no_ack", ack, 0);
            if (err) seen = 1'b1;
         end
         check("wd_err_seen", seen, 1);
         do_xfer(4'b1111, 0, 2, 1'b0, 1'b0);
      end
`endif

      tick();
      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/ser_tx_scheduler.md
Name: ser_tx_scheduler

Overview:
- Shares one byte serializer between NUM_REQ requesters using round-robin arbitration.
- Latches the winner's byte and clock divider, pulses the serializer's store input, and tracks the serializer's empty flag through one full transfer.
- Returns a one-cycle ack to the winner when the transfer completes.
- Sits between client logic (command/response units) and the serializer instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DIV_W, 32, width of the per-requester serial clock divider.
- TIMEOUT_CYC, 65535, cycles allowed per WAIT state before abort (used only with the optional feature).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-requester transfer request (level).
- req_data  in  NUM_REQ*8  byte per requester; requester i uses bits [8i+7:8i].
- req_div  in  NUM_REQ*DIV_W  divider per requester; requester i uses slice i.
- ack  out  NUM_REQ  one-cycle completion pulse, one-hot.
- grant_id  out  3  index of the current or last granted requester.
- busy  out  1  high in every state except IDLE.
- err  out  1  one-cycle abort pulse; constant 0 without the optional feature.
- ser_par_data  out  8  byte to the serializer (registered).
- ser_divider  out  DIV_W  divider to the serializer (registered).
- ser_store  out  1  one-cycle load strobe to the serializer.
- ser_empty  in  1  serializer idle flag (high = idle).

Behaviour:
- Reset values:
  - Outputs: ack=0, grant_id=0, busy=0, err=0, ser_par_data=0, ser_divider=0, ser_store=0.
  - Internal: round-robin pointer last=NUM_REQ-1, so requester 0 has first priority after reset.
  - Reset asserted mid-transfer returns to IDLE immediately; the serializer is not notified.
- State machine: IDLE, LOAD, WAIT_START, WAIT_DONE, ACK.
- IDLE:
  - If req!=0, select the first set bit searching last+1, last+2, ... modulo NUM_REQ.
  - Register grant_id, ser_par_data and ser_divider from the selected slices; set last to the winner; go to LOAD.
- LOAD:
  - ser_store=1 for exactly this cycle; go to WAIT_START.
  - Latency: req seen high in IDLE at edge n gives ser_store high during cycle n+1.
- WAIT_START: wait for ser_empty==0, then go to WAIT_DONE. This guards against the serializer's registered empty flag still being high in the cycle after the store strobe.
- WAIT_DONE: wait for ser_empty==1, then go to ACK.
- ACK:
  - ack[grant_id]=1 for one cycle; go to IDLE.
  - The earliest re-grant is the next cycle, so back-to-back transfers have a 1-cycle IDLE gap.
- Requester rules:
  - req, req_data and req_div must stay stable from assertion until ack.
  - A req deasserted before grant is simply not selected.
  - A req deasserted after grant does not cancel the transfer; ack is still pulsed.
  - Requester data is sampled only in IDLE; later changes have no effect on the transfer.
- Simultaneous events:
  - A req rising during ACK is considered in the next IDLE cycle.
  - If only one requester is active, it is re-granted every transfer.
- Fairness: with all requesters active, grants rotate 0,1,...,NUM_REQ-1,0.
- ser_par_data and ser_divider hold their values after the transfer until the next grant.
- grant_id width is fixed at 3; the unused upper bits are 0.

Optional Feature:
- Macro: SER_TX_TIMEOUT_EN.
- When defined:
  - A 16-bit watchdog counter clears on entry to WAIT_START and WAIT_DONE and increments each cycle spent there.
  - On reaching TIMEOUT_CYC, go to IDLE, pulse err for one cycle, and do not pulse ack.
  - The pointer still advances, so a stuck requester cannot monopolise the serializer.
- When undefined: no counter, err is tied to 0, and the WAIT states wait indefinitely.

Decomposition:
- Shared package ser_pkg holds:
  - State enumeration constants: ST_IDLE=0, ST_LOAD=1, ST_WAIT_START=2, ST_WAIT_DONE=3, ST_ACK=4 (3 bits).
  - SER_BYTE_W=8.
  - Default DIV_W.
- Sub-module rr_pick:
  - Combinational round-robin selector: inputs req and last, outputs index and valid.
  - Instantiated once; reusable by other arbiters in the codebase.

Test Plan:
- Single request: req=4'b0010, data[1]=8'hA5, div[1]=10 → ser_store pulses 1 cycle later with ser_par_data=8'hA5 and ser_divider=10; bench serializer drops empty for 8 cycles; ack=4'b0010 pulses 1 cycle after empty rises.
- All four requesting continuously after reset → grant order 0,1,2,3,0; each ack one-hot; exactly one ser_store per ack.
- Request dropped after grant: req[2] falls during WAIT_DONE → transfer completes and ack[2] still pulses; the next grant skips 2.
- Slow empty response: ser_empty stays high for 3 cycles after ser_store → scheduler holds in WAIT_START, and no premature ack occurs.
- Reset mid-transfer in WAIT_DONE → busy=0, ack=0 and ser_store=0 immediately; the next grant after release goes to requester 0.
- With SER_TX_TIMEOUT_EN and TIMEOUT_CYC=20: ser_empty never falls → err pulses at cycle 20 of WAIT_START, there is no ack, and the next requester is granted.
